// File: rtl/serial_tx_scheduler.sv
// serial_tx_scheduler: round-robin arbiter and sequencer for the serial-out datapath.
// Grants one of two byte requesters, and loads the byte into the PISO for one full sr_clock
// period. It then enables transmission until character_sent rises, and holds an idle gap
// before the next frame.
// Optional feature macro: TX_TIMEOUT_EN (bounds the SEND wait and pulses err on expiry).
module serial_tx_scheduler #(
  parameter int unsigned BIT_CLKS     = 16,
  parameter int unsigned GAP_CLKS     = 32,
  parameter int unsigned TIMEOUT_CLKS = 320
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic [7:0] data_a,
  output logic       ack_a,
  input  logic       req_b,
  input  logic [7:0] data_b,
  output logic       ack_b,
  input  logic       character_sent,
  output logic       sr_load,
  output logic [7:0] sr_data,
  output logic       transmit_en,
  output logic       busy,
  output logic       cur_src,
  output logic       frame_done,
  output logic       err
);

  localparam int unsigned MaxBg   = (BIT_CLKS > GAP_CLKS) ? BIT_CLKS : GAP_CLKS;
  localparam int unsigned MaxClks = (MaxBg > TIMEOUT_CLKS) ? MaxBg : TIMEOUT_CLKS;
  localparam int unsigned CntW    = $clog2(MaxClks) + 1;

  localparam logic [CntW-1:0] LoadReload = CntW'(BIT_CLKS - 1);
  localparam logic [CntW-1:0] GapReload  = CntW'(GAP_CLKS - 1);
`ifdef TX_TIMEOUT_EN
  localparam logic [CntW-1:0] SendReload = CntW'(TIMEOUT_CLKS - 1);
`else
  localparam logic [CntW-1:0] SendReload = '0;
`endif

  localparam logic SrcA = 1'b0;
  localparam logic SrcB = 1'b1;

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StGap} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cs_q;
  logic            cs_rise;
  logic            grant;
  logic            grant_src;
  logic            take;
  logic [7:0]      sr_data_q;
  logic            cur_src_q;
  logic            last_grant_q;
  logic            ack_a_q, ack_b_q;
  logic            done_q, done_d;
`ifdef TX_TIMEOUT_EN
  logic            err_q, err_d;
`endif

  // Only a fresh rising edge counts; a level already high on SEND entry is ignored.
  assign cs_rise = character_sent & ~cs_q;

  // Round-robin pick: on a tie the requester that did not win last time goes first.
  always_comb begin
    grant     = 1'b0;
    grant_src = SrcA;
    if (req_a && req_b) begin
      grant     = 1'b1;
      grant_src = ~last_grant_q;
    end else if (req_a) begin
      grant     = 1'b1;
      grant_src = SrcA;
    end else if (req_b) begin
      grant     = 1'b1;
      grant_src = SrcB;
    end
  end

  assign take = (state_q == StIdle) && grant;

  // Next-state logic; the shared down-counter is reloaded on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef TX_TIMEOUT_EN
    err_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          state_d = StLoad;
          cnt_d   = LoadReload;
        end
      end
      StLoad: begin
        if (cnt_q == '0) begin
          state_d = StSend;
          cnt_d   = SendReload;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StSend: begin
        if (cs_rise) begin
          // An edge on the expiry cycle still counts as a completed frame.
          done_d  = 1'b1;
          state_d = StGap;
          cnt_d   = GapReload;
        end
`ifdef TX_TIMEOUT_EN
        else if (cnt_q == '0) begin
          err_d   = 1'b1;
          state_d = StGap;
          cnt_d   = GapReload;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`endif
      end
      StGap: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and edge-detect registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= character_sent;
    end
  end

  // Grant capture and registered one-cycle pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_data_q    <= 8'h00;
      cur_src_q    <= SrcA;
      last_grant_q <= SrcB;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      ack_a_q <= take & (grant_src == SrcA);
      ack_b_q <= take & (grant_src == SrcB);
      done_q  <= done_d;
      if (take) begin
        sr_data_q    <= (grant_src == SrcB) ? data_b : data_a;
        cur_src_q    <= grant_src;
        last_grant_q <= grant_src;
      end
    end
  end

`ifdef TX_TIMEOUT_EN
  // Timeout abort pulse, aligned with the first GAP cycle like frame_done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign ack_a       = ack_a_q;
  assign ack_b       = ack_b_q;
  assign sr_data     = sr_data_q;
  assign cur_src     = cur_src_q;
  assign frame_done  = done_q;
  assign sr_load     = (state_q == StLoad);
  assign transmit_en = (state_q == StLoad) || (state_q == StSend);
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// tb_serial_tx_scheduler: directed scenarios plus randomized traffic, every cycle compared
// against a phase/elapsed-time model of the scheduler.
module tb_serial_tx_scheduler;

  localparam int BIT_CLKS     = 16;
  localparam int GAP_CLKS     = 32;
  localparam int TIMEOUT_CLKS = 320;

  localparam int PhIdle = 0;
  localparam int PhLoad = 1;
  localparam int PhSend = 2;
  localparam int PhGap  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_a = 1'b0;
  logic [7:0] data_a = 8'h00;
  logic       req_b = 1'b0;
  logic [7:0] data_b = 8'h00;
  logic       character_sent = 1'b0;
  logic       ack_a, ack_b, sr_load, transmit_en, busy, cur_src, frame_done, err;
  logic [7:0] sr_data;
  logic [15:0] dut_out;

  int n_checks = 0;
  int n_pass   = 0;

  serial_tx_scheduler #(
    .BIT_CLKS    (BIT_CLKS),
    .GAP_CLKS    (GAP_CLKS),
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_a         (req_a),
    .data_a        (data_a),
    .ack_a         (ack_a),
    .req_b         (req_b),
    .data_b        (data_b),
    .ack_b         (ack_b),
    .character_sent(character_sent),
    .sr_load       (sr_load),
    .sr_data       (sr_data),
    .transmit_en   (transmit_en),
    .busy          (busy),
    .cur_src       (cur_src),
    .frame_done    (frame_done),
    .err           (err)
  );

  always #5 clk = ~clk;

  assign dut_out = {ack_a, ack_b, sr_load, sr_data, transmit_en, busy, cur_src, frame_done, err};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, got, exp, $time);
  endtask

  // Behavioural model: phase plus cycles elapsed in that phase.
  int         m_phase = PhIdle;
  int         m_age   = 0;
  logic       m_src = 1'b0, m_last = 1'b1, m_prev_cs = 1'b0;
  logic       m_ack_a = 1'b0, m_ack_b = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic [15:0] m_out;

  task automatic model_reset();
    m_phase = PhIdle; m_age = 0; m_src = 1'b0; m_last = 1'b1; m_prev_cs = 1'b0;
    m_ack_a = 1'b0; m_ack_b = 1'b0; m_done = 1'b0; m_err = 1'b0; m_data = 8'h00;
  endtask

  task automatic model_step();
    logic rise, win;
    rise = character_sent && !m_prev_cs;
    m_prev_cs = character_sent;
    m_ack_a = 1'b0; m_ack_b = 1'b0; m_done = 1'b0; m_err = 1'b0;
    case (m_phase)
      PhIdle: begin
        if (req_a || req_b) begin
          win     = (req_a && req_b) ? !m_last : req_b;
          m_data  = win ? data_b : data_a;
          m_src   = win;
          m_last  = win;
          m_ack_a = !win;
          m_ack_b = win;
          m_phase = PhLoad;
          m_age   = 0;
        end
      end
      PhLoad: begin
        m_age++;
        if (m_age == BIT_CLKS) begin m_phase = PhSend; m_age = 0; end
      end
      PhSend: begin
        if (rise) begin
          m_done = 1'b1; m_phase = PhGap; m_age = 0;
        end else begin
          m_age++;
`ifdef TX_TIMEOUT_EN
          if (m_age == TIMEOUT_CLKS) begin m_err = 1'b1; m_phase = PhGap; m_age = 0; end
`endif
        end
      end
      default: begin
        m_age++;
        if (m_age == GAP_CLKS) begin m_phase = PhIdle; m_age = 0; end
      end
    endcase
  endtask

  // Compare every cycle on the falling edge, then advance the model by one cycle.
  always @(negedge clk) begin
    if (!rst) model_reset();
    m_out = {m_ack_a, m_ack_b, m_phase == PhLoad, m_data,
             (m_phase == PhLoad) || (m_phase == PhSend), m_phase != PhIdle,
             m_src, m_done, m_err};
    check("cycle_outputs", dut_out, m_out);
    if (rst) model_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req_a = 1'b0; req_b = 1'b0; character_sent = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_send(input string name);
    int n = 0;
    while (!(transmit_en && !sr_load) && n < 100) begin tick(); n++; end
    check(name, n < 100, 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin tick(); n++; end
    check(name, n < 200, 1);
  endtask

  task automatic serve(input logic exp_src, input logic [7:0] exp_data, input logic drop,
                       input string name);
    int n = 0;
    while (!(ack_a || ack_b) && n < 300) begin tick(); n++; end
    check({name, "_ack_seen"}, n < 300, 1);
    check({name, "_src"}, {ack_b, ack_a, cur_src}, {exp_src, !exp_src, exp_src});
    check({name, "_data"}, sr_data, exp_data);
    if (drop) begin req_a = 1'b0; req_b = 1'b0; end
    wait_send({name, "_send_wait"});
    tick();
    character_sent = 1'b1;
    tick();
    character_sent = 1'b0;
    check({name, "_done"}, frame_done, 1);
    wait_idle({name, "_idle_wait"});
  endtask

  initial begin
    int n, g, k, cs_div;

    // Reset: all outputs low, then idle after release.
    tick(); tick();
    check("reset_outputs", dut_out, 16'h0000);
    rst = 1'b1;
    tick();
    check("reset_release_busy", busy, 0);

    // Single A frame with exact load and gap lengths.
    req_a = 1'b1; data_a = 8'h99;
    tick();
    check("single_ack", {ack_a, ack_b, sr_load, sr_data}, {3'b101, 8'h99});
    req_a = 1'b0;
    n = 1;
    tick();
    while (sr_load && n < 100) begin n++; tick(); end
    check("single_load_len", n, BIT_CLKS);
    check("single_send_entry", {transmit_en, sr_load}, 2'b10);
    tick(); tick();
    character_sent = 1'b1;
    tick();
    check("single_done", {frame_done, transmit_en}, 2'b10);
    character_sent = 1'b0;
    g = 1; n = 0;
    tick();
    while (busy && !transmit_en && n < 100) begin g++; tick(); n++; end
    check("single_gap_len", g, GAP_CLKS);
    check("single_idle", busy, 0);

    // Tie from reset: A, B, A.
    do_reset();
    req_a = 1'b1; req_b = 1'b1; data_a = 8'h11; data_b = 8'h22;
    serve(1'b0, 8'h11, 1'b0, "tie1");
    serve(1'b1, 8'h22, 1'b0, "tie2");
    serve(1'b0, 8'h11, 1'b0, "tie3");

    // Stray character_sent edges in IDLE and LOAD are ignored.
    do_reset();
    character_sent = 1'b1;
    tick();
    character_sent = 1'b0;
    tick();
    check("stray_idle", {busy, frame_done}, 2'b00);
    req_a = 1'b1; data_a = 8'h3C;
    tick();
    req_a = 1'b0;
    tick(); tick(); tick();
    character_sent = 1'b1;
    tick();
    character_sent = 1'b0;
    tick();
    check("stray_load", {sr_load, frame_done}, 2'b10);
    wait_send("stray_send_wait");
    tick(); tick();
    check("stray_send_pending", {transmit_en, frame_done}, 2'b10);
    character_sent = 1'b1;
    tick();
    character_sent = 1'b0;
    check("stray_done", frame_done, 1);
    wait_idle("stray_idle_wait");

    // Reset during SEND abandons the frame at once.
    do_reset();
    req_a = 1'b1; data_a = 8'h77;
    tick();
    req_a = 1'b0;
    wait_send("midrst_send_wait");
    tick();
    rst = 1'b0;
    #1;
    check("midrst_outputs", {transmit_en, sr_load, busy, sr_data}, 11'h000);
    tick(); tick();
    rst = 1'b1; req_a = 1'b1; data_a = 8'h5A;
    serve(1'b0, 8'h5A, 1'b1, "midrst_after");

`ifdef TX_TIMEOUT_EN
    // Timeout: err exactly TIMEOUT_CLKS cycles after SEND entry, no frame_done.
    do_reset();
    req_a = 1'b1; data_a = 8'hC3;
    tick();
    req_a = 1'b0;
    wait_send("tmo_send_wait");
    k = 0;
    while (!err && k < 400) begin tick(); k++; end
    check("tmo_latency", k, TIMEOUT_CLKS);
    check("tmo_state", {frame_done, transmit_en, busy}, 3'b001);
    wait_idle("tmo_idle_wait");
`endif

    // Randomized traffic with occasional resets; checked each cycle by the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      cs_div = (i < 2500) ? 11 : 400;
      req_a  = ($urandom_range(0, 3) == 0);
      req_b  = ($urandom_range(0, 3) == 0);
      data_a = 8'($urandom);
      data_b = 8'($urandom);
      if ($urandom_range(0, cs_div) == 0) character_sent = ~character_sent;
      rst = ($urandom_range(0, 999) != 0);
      tick();
    end
    rst = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
